// File: rtl/tap_period_ctrl_pkg.sv
// Shared TapTempo definitions: FSM state encoding, tick period and default limits,
// also used by the timepulse generator and the BPM divider.
package tap_period_ctrl_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } tap_state_e;

  localparam int TP_PER_NS         = 5120;
  localparam int DEF_PERIOD_W      = 21;
  localparam int DEF_MAX_PERIOD_TP = 2000000;
  localparam int DEF_MIN_PERIOD_TP = 11719;
  localparam int AVG_DEPTH         = 4;

  // History fill level after one more accepted period, saturating at the depth.
  function automatic logic [2:0] avg_next_cnt(input logic [2:0] cnt);
    return (cnt >= 3'd4) ? 3'd4 : (cnt + 3'd1);
  endfunction

endpackage

// File: rtl/tap_period_ctrl_if.sv
// Period hand-off port: measured period with valid/ready flow control.
interface tap_period_ctrl_if #(
  parameter int PERIOD_W = 21
) ();

  logic [PERIOD_W-1:0] period_o;
  logic                period_valid_o;
  logic                period_ready_i;

  modport master (
    output period_o,
    output period_valid_o,
    input  period_ready_i
  );

  modport slave (
    input  period_o,
    input  period_valid_o,
    output period_ready_i
  );

endinterface

// File: rtl/tap_period_ctrl_period_avg.sv
// Running mean of the last four accepted periods (4-deep history plus sum).
// Mean is taken over 1, 2, 2 (repeated), then 4 periods while the history fills.
module tap_period_ctrl_period_avg
  import tap_period_ctrl_pkg::*;
#(
  parameter int PERIOD_W = DEF_PERIOD_W
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clr_i,
  input  logic                load_i,
  input  logic [PERIOD_W-1:0] period_i,
  output logic [PERIOD_W-1:0] mean_o,
  output logic                done_o
);

  localparam int SUM_W = PERIOD_W + 2;

  logic [PERIOD_W-1:0] hist_q [AVG_DEPTH];
  logic [SUM_W-1:0]    sum_q;
  logic [SUM_W-1:0]    sum_d;
  logic [2:0]          cnt_q;
  logic [2:0]          cnt_d;
  logic [PERIOD_W-1:0] mean_q;
  logic [PERIOD_W-1:0] mean_d;
  logic                done_q;

  // Oldest entry leaves the sum only once the history is full.
  always_comb begin
    sum_d = sum_q + SUM_W'(period_i)
          - ((cnt_q == 3'd4) ? SUM_W'(hist_q[AVG_DEPTH-1]) : {SUM_W{1'b0}});
    cnt_d = avg_next_cnt(cnt_q);
    case (cnt_d)
      3'd1:    mean_d = period_i;
      3'd2:    mean_d = PERIOD_W'(sum_d >> 1);
      3'd3:    mean_d = mean_q;
      3'd4:    mean_d = PERIOD_W'(sum_d >> 2);
      default: mean_d = mean_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < AVG_DEPTH; i++) begin
        hist_q[i] <= {PERIOD_W{1'b0}};
      end
      sum_q  <= {SUM_W{1'b0}};
      cnt_q  <= 3'd0;
      mean_q <= {PERIOD_W{1'b0}};
      done_q <= 1'b0;
    end else if (clr_i) begin
      for (int i = 0; i < AVG_DEPTH; i++) begin
        hist_q[i] <= {PERIOD_W{1'b0}};
      end
      sum_q  <= {SUM_W{1'b0}};
      cnt_q  <= 3'd0;
      mean_q <= {PERIOD_W{1'b0}};
      done_q <= 1'b0;
    end else begin
      done_q <= load_i;
      if (load_i) begin
        hist_q[0] <= period_i;
        for (int i = 1; i < AVG_DEPTH; i++) begin
          hist_q[i] <= hist_q[i-1];
        end
        sum_q  <= sum_d;
        cnt_q  <= cnt_d;
        mean_q <= mean_d;
      end else begin
        sum_q  <= sum_q;
        cnt_q  <= cnt_q;
        mean_q <= mean_q;
      end
    end
  end

  assign mean_o = mean_q;
  assign done_o = done_q;

endmodule

// File: rtl/tap_period_ctrl.sv
// Tap interval measurement: detects tap edges, re-phases the timepulse generator,
// counts ticks between taps and offers the period on a valid/ready port.
// Build option TAP_PERIOD_AVG_EN reports the mean of the last four periods instead.
module tap_period_ctrl
  import tap_period_ctrl_pkg::*;
#(
  parameter int PERIOD_W      = DEF_PERIOD_W,
  parameter int MAX_PERIOD_TP = DEF_MAX_PERIOD_TP,
  parameter int MIN_PERIOD_TP = DEF_MIN_PERIOD_TP
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              tap_i,
  input  logic              tp_i,
  output logic              tp_rst_o,
  output logic              timeout_o,
  output logic              busy_o,
  tap_period_ctrl_if.master per_if
);

  if (MAX_PERIOD_TP >= (2 ** PERIOD_W)) begin : g_width_chk
    $error("tap_period_ctrl: MAX_PERIOD_TP does not fit in PERIOD_W bits");
  end

  localparam logic [PERIOD_W-1:0] MAX_C   = PERIOD_W'(MAX_PERIOD_TP);
  localparam logic [PERIOD_W-1:0] MIN_C   = PERIOD_W'(MIN_PERIOD_TP);
  localparam logic [PERIOD_W-1:0] CNT_SAT = {PERIOD_W{1'b1}};
  localparam logic [PERIOD_W-1:0] CNT_ONE = {{(PERIOD_W-1){1'b0}}, 1'b1};

  tap_state_e          state_q;
  logic [PERIOD_W-1:0] counter_q;
  logic [PERIOD_W-1:0] cnt_inc_d;
  logic [PERIOD_W-1:0] raw_period_d;
  logic                tap_q;
  logic                tap_rise_q;
  logic                tp_rst_q;
  logic                timeout_q;
  logic                busy_q;
  logic [PERIOD_W-1:0] period_q;
  logic                valid_q;
  logic                timeout_hit;
  logic                tap_accept;
  logic                load_en;
  logic [PERIOD_W-1:0] load_val;

  // Timeout outranks an accepted tap; a tick coinciding with the tap is counted.
  always_comb begin
    cnt_inc_d    = (counter_q == CNT_SAT) ? counter_q : (counter_q + CNT_ONE);
    timeout_hit  = (state_q == COUNT) && (counter_q >= MAX_C);
    tap_accept   = (state_q == COUNT) && !timeout_hit && tap_rise_q && (counter_q >= MIN_C);
    raw_period_d = tp_i ? cnt_inc_d : counter_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      counter_q  <= {PERIOD_W{1'b0}};
      tap_q      <= 1'b0;
      tap_rise_q <= 1'b0;
      tp_rst_q   <= 1'b0;
      timeout_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      tap_q      <= tap_i;
      tap_rise_q <= tap_i & ~tap_q;
      tp_rst_q   <= 1'b0;
      timeout_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          counter_q <= {PERIOD_W{1'b0}};
          if (tap_rise_q) begin
            tp_rst_q <= 1'b1;
            state_q  <= COUNT;
            busy_q   <= 1'b1;
          end else begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
          end
        end
        COUNT: begin
          if (timeout_hit) begin
            timeout_q <= 1'b1;
            counter_q <= {PERIOD_W{1'b0}};
            state_q   <= IDLE;
            busy_q    <= 1'b0;
          end else if (tap_accept) begin
            counter_q <= {PERIOD_W{1'b0}};
            tp_rst_q  <= 1'b1;
            busy_q    <= 1'b1;
          end else if (tp_i) begin
            counter_q <= cnt_inc_d;
            busy_q    <= 1'b1;
          end else begin
            counter_q <= counter_q;
            busy_q    <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          counter_q <= {PERIOD_W{1'b0}};
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

`ifdef TAP_PERIOD_AVG_EN
  logic [PERIOD_W-1:0] avg_mean;
  logic                avg_done;

  tap_period_ctrl_period_avg #(
    .PERIOD_W (PERIOD_W)
  ) u_period_avg (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (timeout_hit),
    .load_i   (tap_accept),
    .period_i (raw_period_d),
    .mean_o   (avg_mean),
    .done_o   (avg_done)
  );

  assign load_en  = avg_done;
  assign load_val = avg_mean;
`else
  assign load_en  = tap_accept;
  assign load_val = raw_period_d;
`endif

  // A fresh period always wins over a pending or completing transfer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      period_q <= {PERIOD_W{1'b0}};
      valid_q  <= 1'b0;
    end else if (load_en) begin
      period_q <= load_val;
      valid_q  <= 1'b1;
    end else if (valid_q && per_if.period_ready_i) begin
      period_q <= period_q;
      valid_q  <= 1'b0;
    end else begin
      period_q <= period_q;
      valid_q  <= valid_q;
    end
  end

  assign tp_rst_o              = tp_rst_q;
  assign timeout_o             = timeout_q;
  assign busy_o                = busy_q;
  assign per_if.period_o       = period_q;
  assign per_if.period_valid_o = valid_q;

endmodule
